// File: rtl/float32_sum_pkg.sv
// Shared definitions for the float32 row summation path.
// Holds the default word width, the additive-identity constant used to pad
// short rows, and the row collector FSM state type.
package float32_sum_pkg;

  localparam int unsigned FLOAT32_BITS = 32;

  // +0.0: leaves the adder tree result unchanged for lanes a short row does not fill.
  localparam logic [FLOAT32_BITS-1:0] FLOAT32_POS_ZERO = 32'h0000_0000;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } collect_state_e;

endpackage

// File: rtl/row_collector_float32_if.sv
// Upstream word stream into the row collector.
// Signals:
//   s_valid_i  - word valid (source -> collector)
//   s_ready_o  - collector accepts a word this cycle (collector -> source)
//   s_data_i   - float32 element
//   s_last_i   - final element of a row
// Modports: master = word source, slave = row collector.
interface row_collector_float32_if #(
  parameter int unsigned BITS_PER_SYMBOL = float32_sum_pkg::FLOAT32_BITS
);

  logic                       s_valid_i;
  logic                       s_ready_o;
  logic [BITS_PER_SYMBOL-1:0] s_data_i;
  logic                       s_last_i;

  modport master (
    output s_valid_i,
    output s_data_i,
    output s_last_i,
    input  s_ready_o
  );

  modport slave (
    input  s_valid_i,
    input  s_data_i,
    input  s_last_i,
    output s_ready_o
  );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for a single valid bit.
// Every input pulse reappears DEPTH cycles later, back-to-back pulses kept apart.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset, flushes all pending pulses
//   valid_i  - pulse in
//   valid_o  - pulse out, DEPTH cycles later (combinational pass-through when DEPTH = 0)
module valid_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic valid_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign valid_o = valid_i;
    end else if (DEPTH == 1) begin : g_single
      logic stage_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) stage_q <= 1'b0;
        else       stage_q <= valid_i;
      end

      assign valid_o = stage_q;
    end else begin : g_chain
      logic [DEPTH-1:0] pipe_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) pipe_q <= '0;
        else       pipe_q <= {pipe_q[DEPTH-2:0], valid_i};
      end

      assign valid_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/row_collector_float32.sv
// Collects a stream of float32 words into one packed row for a parallel
// adder tree. Short rows (s_last_i early) are padded with +0.0. Each row is
// followed by a single EMIT cycle in which the source is stalled and the
// shadow row is cleared. Words are never interpreted; they pass bit-exact.
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - synchronous active-high reset
//   s_if         - upstream word stream (slave side)
//   data_o       - packed row, lane k at [BITS_PER_SYMBOL*k +: BITS_PER_SYMBOL]
//   row_valid_o  - one-cycle pulse, data_o/row_count_o carry a new row
//   row_count_o  - number of real lanes in data_o
//   sum_valid_o  - row_valid_o delayed by SUM_LATENCY cycles
module row_collector_float32
  import float32_sum_pkg::*;
#(
  parameter int unsigned NUMBER_OF_INPUTS = 1024,
  parameter int unsigned BITS_PER_SYMBOL  = FLOAT32_BITS,
  parameter int unsigned SUM_LATENCY      = $clog2(NUMBER_OF_INPUTS)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  row_collector_float32_if.slave                      s_if,
  output logic [NUMBER_OF_INPUTS*BITS_PER_SYMBOL-1:0] data_o,
  output logic                                        row_valid_o,
  output logic [$clog2(NUMBER_OF_INPUTS):0]           row_count_o,
  output logic                                        sum_valid_o
);

  localparam int unsigned CW       = $clog2(NUMBER_OF_INPUTS) + 1;
  localparam int unsigned LW       = (NUMBER_OF_INPUTS > 1) ? $clog2(NUMBER_OF_INPUTS) : 1;
  localparam int unsigned LAST_IDX = NUMBER_OF_INPUTS - 1;

  localparam logic [BITS_PER_SYMBOL-1:0] LANE_ZERO = BITS_PER_SYMBOL'(FLOAT32_POS_ZERO);
  localparam logic [NUMBER_OF_INPUTS-1:0][BITS_PER_SYMBOL-1:0] ROW_ZERO =
    {NUMBER_OF_INPUTS{LANE_ZERO}};

  collect_state_e                                    state_q;
  logic [CW-1:0]                                     idx_q;
  logic [LW-1:0]                                     lane;
  logic [NUMBER_OF_INPUTS-1:0][BITS_PER_SYMBOL-1:0]  shadow_q;
  logic [NUMBER_OF_INPUTS-1:0][BITS_PER_SYMBOL-1:0]  shadow_nxt;
  logic                                              xfer;
  logic                                              row_done;

  // Ready is a pure decode of the state register.
  assign s_if.s_ready_o = (state_q == ST_FILL);

  assign xfer     = s_if.s_valid_i && s_if.s_ready_o;
  assign row_done = s_if.s_last_i || (idx_q == CW'(LAST_IDX));
  assign lane     = LW'(idx_q);

  // Shadow row with the incoming word merged in, so the completing word can
  // be published on the same edge that accepts it.
  always_comb begin
    shadow_nxt       = shadow_q;
    shadow_nxt[lane] = s_if.s_data_i;
  end

  // Row FSM together with the shadow and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      shadow_q    <= ROW_ZERO;
      data_o      <= '0;
      row_count_o <= '0;
      row_valid_o <= 1'b0;
    end else begin
      row_valid_o <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (xfer) begin
            shadow_q <= shadow_nxt;
            idx_q    <= idx_q + CW'(1);
            if (row_done) begin
              data_o      <= shadow_nxt;
              row_count_o <= idx_q + CW'(1);
              row_valid_o <= 1'b1;
              state_q     <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          // Clear so lanes of the next (possibly short) row start at +0.0.
          shadow_q <= ROW_ZERO;
          idx_q    <= '0;
          state_q  <= ST_FILL;
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH (SUM_LATENCY)
  ) u_sum_valid_dly (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (row_valid_o),
    .valid_o (sum_valid_o)
  );

endmodule

// File: tb/tb_row_collector_float32.sv
// Self-checking bench for row_collector_float32 (4 lanes, sum latency 2).
// A queue-based reference model predicts rows, ready, and the delayed sum valid.
module tb_row_collector_float32;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned SL = 2;
  localparam int unsigned DW = N * W;

  logic          clk_i;
  logic          rst_i;
  logic [DW-1:0] data_o;
  logic          row_valid_o;
  logic [2:0]    row_count_o;
  logic          sum_valid_o;

  row_collector_float32_if #(.BITS_PER_SYMBOL(W)) mif ();

  row_collector_float32 #(
    .NUMBER_OF_INPUTS (N),
    .BITS_PER_SYMBOL  (W),
    .SUM_LATENCY      (SL)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_if        (mif),
    .data_o      (data_o),
    .row_valid_o (row_valid_o),
    .row_count_o (row_count_o),
    .sum_valid_o (sum_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [W-1:0]  words[$];
  bit            m_emit = 1'b0;
  logic [DW-1:0] e_data = '0;
  int            e_count = 0;
  bit            e_rv = 1'b0;
  bit            e_sv = 1'b0;
  bit            hist[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock edge of the behavioural model: a row is the list of accepted
  // words, published when last is seen or the row is full; one dead cycle follows.
  task automatic model_edge(input bit r, input bit v, input logic [W-1:0] d, input bit l);
    if (r) begin
      words.delete();
      m_emit  = 1'b0;
      e_data  = '0;
      e_count = 0;
      e_rv    = 1'b0;
      e_sv    = 1'b0;
      hist    = '{};
      for (int i = 0; i < SL; i++) hist.push_back(1'b0);
      return;
    end
    if (m_emit) begin
      m_emit = 1'b0;
      e_rv   = 1'b0;
    end else begin
      e_rv = 1'b0;
      if (v) begin
        words.push_back(d);
        if (l || words.size() == N) begin
          e_data = '0;
          for (int i = 0; i < words.size(); i++) e_data[W*i +: W] = words[i];
          e_count = words.size();
          e_rv    = 1'b1;
          m_emit  = 1'b1;
          words.delete();
        end
      end
    end
    // sum_valid is the row_valid sequence shifted by SL cycles.
    hist.push_back(e_rv);
    e_sv = hist.pop_front();
  endtask

  task automatic check_all();
    check_eq("s_ready",   DW'(mif.s_ready_o), DW'(!m_emit));
    check_eq("row_valid", DW'(row_valid_o),   DW'(e_rv));
    check_eq("sum_valid", DW'(sum_valid_o),   DW'(e_sv));
    check_eq("data",      data_o,             e_data);
    check_eq("row_count", DW'(row_count_o),   DW'(e_count));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare.
  task automatic step(input bit r, input bit v, input logic [W-1:0] d, input bit l);
    rst_i         = r;
    mif.s_valid_i = v;
    mif.s_data_i  = d;
    mif.s_last_i  = l;
    @(posedge clk_i);
    #1;
    model_edge(r, v, d, l);
    check_all();
  endtask

  initial begin
    logic [W-1:0] gap_words[4];
    int           g;

    for (int i = 0; i < SL; i++) hist.push_back(1'b0);
    rst_i         = 1'b1;
    mif.s_valid_i = 1'b0;
    mif.s_data_i  = '0;
    mif.s_last_i  = 1'b0;

    // Reset, then ready the cycle after release.
    step(1, 0, 32'h0, 0);
    step(1, 1, 32'hDEAD_BEEF, 1);
    check_eq("rst_data",  data_o, '0);
    check_eq("rst_count", DW'(row_count_o), '0);
    step(0, 0, 32'h0, 0);
    check_eq("ready_after_rst", DW'(mif.s_ready_o), DW'(1));

    // Full row, back-to-back.
    step(0, 1, 32'h3F80_0000, 0);
    step(0, 1, 32'h4000_0000, 0);
    step(0, 1, 32'h4040_0000, 0);
    step(0, 1, 32'h4080_0000, 1);
    check_eq("full_data",  data_o, 128'h4080_0000_4040_0000_4000_0000_3F80_0000);
    check_eq("full_count", DW'(row_count_o), DW'(4));
    check_eq("full_pulse", DW'(row_valid_o), DW'(1));
    check_eq("full_ready", DW'(mif.s_ready_o), DW'(0));
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    check_eq("sum_lat", DW'(sum_valid_o), DW'(1));

    // Short row, then a full row must show no stale lanes.
    step(0, 1, 32'h3F80_0000, 0);
    step(0, 1, 32'h3F80_0000, 1);
    check_eq("short_data",  data_o, 128'h0000_0000_0000_0000_3F80_0000_3F80_0000);
    check_eq("short_count", DW'(row_count_o), DW'(2));
    step(0, 1, 32'h1111_1111, 1);  // offered during the dead cycle, must be dropped
    step(0, 1, 32'hA000_0001, 0);
    step(0, 1, 32'hA000_0002, 0);
    step(0, 1, 32'hA000_0003, 0);
    step(0, 1, 32'hA000_0004, 0);
    check_eq("after_short", data_o, 128'hA000_0004_A000_0003_A000_0002_A000_0001);
    step(0, 0, 32'h0, 0);

    // Gaps: valid 1,0,0 repeating; garbage on data while idle.
    gap_words = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, gap_words[i], 0);
      if (i < 3) begin
        step(0, 0, $urandom, 1);
        step(0, 0, $urandom, 1);
      end
    end
    check_eq("gap_data", data_o, 128'h0000_0040_0000_0030_0000_0020_0000_0010);
    step(0, 0, 32'h0, 0);

    // Back-to-back short rows with valid held high.
    step(0, 1, 32'h0000_0001, 0);
    step(0, 1, 32'h0000_0002, 1);
    step(0, 1, 32'h0000_0099, 0);
    step(0, 1, 32'h0000_0003, 1);
    step(0, 1, 32'h0000_0099, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);

    // Reset mid-row discards the partial row.
    step(0, 1, 32'h5555_0001, 0);
    step(0, 1, 32'h5555_0002, 0);
    step(1, 0, 32'h0, 0);
    step(0, 1, 32'h6666_0001, 0);
    step(0, 1, 32'h6666_0002, 0);
    step(0, 1, 32'h6666_0003, 0);
    step(0, 1, 32'h6666_0004, 0);
    check_eq("post_rst_count", DW'(row_count_o), DW'(4));
    check_eq("post_rst_data",  data_o, 128'h6666_0004_6666_0003_6666_0002_6666_0001);

    // Reset during the dead cycle flushes the pending sum_valid pulse.
    step(1, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    check_eq("flushed_sum", DW'(sum_valid_o), DW'(0));

    // Special float encodings pass unchanged.
    step(0, 1, 32'h7FC0_0000, 0);
    step(0, 1, 32'hFF80_0000, 0);
    step(0, 1, 32'h0000_0001, 0);
    step(0, 1, 32'h8000_0000, 1);
    check_eq("bit_exact", data_o, 128'h8000_0000_0000_0001_FF80_0000_7FC0_0000);
    step(0, 0, 32'h0, 0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      g = $urandom_range(0, 59);
      step(g == 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 4; c++) step(0, 0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/row_collector_float32.md
ROW_COLLECTOR_FLOAT32 -- requirements
Module: row_collector_float32

Interface
REQ-001 SHALL have parameter NUMBER_OF_INPUTS, default 1024, lanes per row presented to the parallel float32 adder tree.
REQ-002 SHALL have parameter BITS_PER_SYMBOL, default 32, width of one IEEE-754 single word.
REQ-003 SHALL have parameter SUM_LATENCY, default $clog2(NUMBER_OF_INPUTS), register stages of the downstream adder tree.
REQ-004 clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 s_valid_i  input  1  upstream word valid.
REQ-007 s_ready_o  output  1  block accepts a word this cycle.
REQ-008 s_data_i  input  BITS_PER_SYMBOL  float32 element.
REQ-009 s_last_i  input  1  word is final element of a row (short row allowed).
REQ-010 data_o  output  NUMBER_OF_INPUTS*BITS_PER_SYMBOL  packed row, lane k at bits [32k+31:32k]; feeds the adder tree data input.
REQ-011 row_valid_o  output  1  one-cycle pulse, data_o updated this cycle.
REQ-012 row_count_o  output  $clog2(NUMBER_OF_INPUTS)+1  number of real lanes in current data_o (1..NUMBER_OF_INPUTS).
REQ-013 sum_valid_o  output  1  row_valid_o delayed SUM_LATENCY cycles; marks tree output valid for that row.

Function
REQ-014 Handshake: word transfers iff s_valid_i && s_ready_o on a rising edge; s_data_i/s_last_i ignored otherwise.
REQ-015 FSM states FILL, EMIT; s_ready_o = 1 in FILL, 0 in EMIT (combinational from state only).
REQ-016 FILL: transferred word written to shadow lane idx; idx increments by 1.
REQ-017 FILL -> EMIT when transfer occurs with idx == NUMBER_OF_INPUTS-1 or s_last_i = 1; otherwise stay FILL.
REQ-018 EMIT (exactly one cycle): data_o <= shadow; row_count_o <= idx; row_valid_o = 1; shadow cleared to all-zero; idx <= 0; -> FILL.
REQ-019 Unfilled lanes of a short row SHALL be 32'h0000_0000 (+0.0, additive identity) in data_o.
REQ-020 data_o and row_count_o SHALL hold value between EMIT cycles.
REQ-021 Full row with s_last_i on lane NUMBER_OF_INPUTS-1: single EMIT, row_count_o = NUMBER_OF_INPUTS, no empty row emitted.
REQ-022 Throughput: full row costs NUMBER_OF_INPUTS+1 cycles; row of m words costs m+1 cycles with s_valid_i held high.
REQ-023 sum_valid_o: SUM_LATENCY-deep shift register of row_valid_o; back-to-back pulses preserved independently.
REQ-024 No arithmetic on float data; words pass bit-exact (NaN/Inf/denormal untouched).

Reset
REQ-025 On rst_i = 1 at a clock edge: state FILL, idx 0, shadow 0, data_o 0, row_count_o 0, row_valid_o 0, sum_valid_o pipeline 0.
REQ-026 s_ready_o = 1 in the cycle after reset release; partial row in progress at reset is discarded, not emitted.
REQ-027 Reset asserted during EMIT SHALL suppress that row_valid_o pulse and all pending sum_valid_o pulses.

Structure
REQ-028 Shared package float32_sum_pkg SHALL hold BITS_PER_SYMBOL default, FLOAT32_POS_ZERO constant, and FSM state enum type.
REQ-029 One sub-module valid_delay_line (parameter DEPTH) SHALL implement the sum_valid_o shift register.
REQ-030 No other sub-modules; shadow and output registers are flat in this module.

Verification (bench NUMBER_OF_INPUTS=4, SUM_LATENCY=2)
REQ-031 Full row: words 3F800000,40000000,40400000,40800000 back-to-back, last on 4th -> cycle 5 row_valid_o=1, data_o={40800000,40400000,40000000,3F800000}, row_count_o=4, s_ready_o=0 that cycle.
REQ-032 Short row: 2 words 3F800000,3F800000 with last on 2nd -> data_o lanes 2,3 = 0, row_count_o=2, following full row has no stale lanes.
REQ-033 Backpressure/gaps: s_valid_i toggled 1,0,0,1,... -> only valid words captured in order, idx unaffected by idle cycles.
REQ-034 Latency: two back-to-back rows -> sum_valid_o pulses exactly 2 cycles after each row_valid_o.
REQ-035 Reset mid-row: rst_i after 2 of 4 words -> no row_valid_o, next 4-word row emits correctly with row_count_o=4.
REQ-036 Bit-exactness: lanes 7FC00000, FF800000, 00000001, 80000000 -> emitted unchanged.
